serial_subtractor: RTL

- Bit-serial N-bit subtractor computing diff = A - B, one bit per clock, LSB first, through a single borrow flip-flop.
- Counterpart to the combinational parallel adder: it performs the inverse operation and trades area for N-cycle latency.
- Has a start/busy/done handshake and sits between operand registers and any consumer that tolerates multi-cycle latency.

---
 rtl/serial_subtractor.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial N-bit subtractor: diff = A - B (mod 2^N), one bit per clock,
//   LSB first, through a single borrow flip-flop. A start/busy/done handshake
//   frames each operation. diff/bout (and ovf) change only on the completing
//   edge, so a consumer never observes a partial result.
//
// Parameters
//   N      operand and result width in bits (N >= 2)
//
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset; clears all state
//   start  in   request a subtraction (accepted in IDLE or DONE)
//   A      in   [N] minuend, captured on the accepting edge only
//   B      in   [N] subtrahend, captured on the accepting edge only
//   busy   out  high while a subtraction is in progress
//   done   out  one-cycle pulse when diff/bout become valid
//   diff   out  [N] A - B modulo 2^N, held until the next result
//   bout   out  final borrow (1 when unsigned A < B)
//   ovf    out  signed overflow of A - B (only with SERIAL_SUB_OVF_EN)
//
// Configuration
//   SERIAL_SUB_OVF_EN  when defined, adds the ovf output port and its flop.
// ---------------------------------------------------------------------------
module serial_subtractor #(
  parameter int N = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] diff,
  output logic         bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          borrow_q, borrow_d;
  logic [N-1:0]  sa_q, sa_d;
  logic [N-1:0]  sb_q, sb_d;
  logic [N-1:0]  res_q, res_d;
  logic [N-1:0]  diff_q, diff_d;
  logic          bout_q, bout_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
`ifdef SERIAL_SUB_OVF_EN
  logic          ovf_q, ovf_d;
`endif

  // One full-subtractor slice operating on the current LSBs.
  logic         bit_a, bit_b, d_bit, borrow_nx;
  logic [N-1:0] res_shift;

  assign bit_a     = sa_q[0];
  assign bit_b     = sb_q[0];
  assign d_bit     = bit_a ^ bit_b ^ borrow_q;
  assign borrow_nx = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & borrow_q);
  // Result bits enter from the MSB side so after N shifts bit 0 sits at [0].
  assign res_shift = {d_bit, res_q[N-1:1]};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    borrow_d = borrow_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    res_d    = res_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
    ovf_d    = ovf_q;
`endif

    case (state_q)
      S_IDLE, S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
        if (start) begin
          sa_d     = A;
          sb_d     = B;
          res_d    = '0;
          borrow_d = 1'b0;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = S_SHIFT;
        end
      end

      S_SHIFT: begin
        borrow_d = borrow_nx;
        res_d    = res_shift;
        sa_d     = {1'b0, sa_q[N-1:1]};
        sb_d     = {1'b0, sb_q[N-1:1]};
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          diff_d  = res_shift;
          bout_d  = borrow_nx;
`ifdef SERIAL_SUB_OVF_EN
          // At the last bit, bit_a/bit_b are the operand sign bits and d_bit
          // is the result sign bit.
          ovf_d   = (bit_a ^ bit_b) & (d_bit ^ bit_a);
`endif
          cnt_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end

      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      sa_q     <= '0;
      sb_q     <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule
